// File: rtl/seq_multiplier_if.sv
// Operand/result bundle between the control unit and seq_multiplier.
// The master side issues START with A/B; the slave side returns HI/LO, BUSY and DONE.
interface seq_multiplier_if #(
  parameter int WIDTH = 32
) ();
  logic             START;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic             BUSY;
  logic             DONE;

  modport master (
    output START, A, B,
    input  HI, LO, BUSY, DONE
  );

  modport slave (
    input  START, A, B,
    output HI, LO, BUSY, DONE
  );
endinterface

// File: rtl/seq_multiplier.sv
// Shift-and-add multiplier: WIDTH iterations of one ripple add plus a right shift.
// Define SEQ_MULT_SIGNED_EN for two's-complement operands (magnitude multiply + final negate).
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  seq_multiplier_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  if (WIDTH < 4 || WIDTH > 64) begin : g_bad_width
    $error("seq_multiplier: WIDTH must be in 4..64");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] m_reg;
  logic [WIDTH-1:0] q_reg;
  // The carry of each add shifts straight into the accumulator MSB, so the
  // extra carry bit of the accumulator never needs to be held across edges.
  logic [WIDTH-1:0] acc_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic             busy_reg;
  logic             done_reg;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH:0]     carry;
  logic [WIDTH-1:0]   acc_next;
  logic [WIDTH-1:0]   q_next;
  logic [2*WIDTH-1:0] product_next;
  logic [WIDTH-1:0]   m_load;
  logic [WIDTH-1:0]   q_load;

  assign addend   = q_reg[0] ? m_reg : '0;
  assign carry[0] = 1'b0;

  // Ripple chain of full adders: S = ACC + addend, C = carry[WIDTH].
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_adder
    logic p;
    assign p             = acc_reg[gi] ^ addend[gi];
    assign sum[gi]       = p ^ carry[gi];
    assign carry[gi + 1] = (acc_reg[gi] & addend[gi]) | (carry[gi] & p);
  end

  assign acc_next = {carry[WIDTH], sum[WIDTH-1:1]};
  assign q_next   = {sum[0], q_reg[WIDTH-1:1]};

`ifdef SEQ_MULT_SIGNED_EN
  logic sign_reg;
  logic sign_load;

  // Negating the most negative value wraps back to 2^(WIDTH-1), which is the
  // correct magnitude when read as unsigned.
  assign m_load       = bus.A[WIDTH-1] ? -bus.A : bus.A;
  assign q_load       = bus.B[WIDTH-1] ? -bus.B : bus.B;
  assign sign_load    = bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
  assign product_next = sign_reg ? -{acc_next, q_next} : {acc_next, q_next};

  always_ff @(posedge CLK) begin
    if (RST) begin
      sign_reg <= 1'b0;
    end else if ((state_reg == ST_IDLE || state_reg == ST_DONE) && bus.START) begin
      sign_reg <= sign_load;
    end
  end
`else
  assign m_load       = bus.A;
  assign q_load       = bus.B;
  assign product_next = {acc_next, q_next};
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= ST_IDLE;
      m_reg     <= '0;
      q_reg     <= '0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          done_reg <= 1'b0;
          if (bus.START) begin
            m_reg     <= m_load;
            q_reg     <= q_load;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= ST_RUN;
          end else begin
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        ST_RUN: begin
          acc_reg <= acc_next;
          q_reg   <= q_next;
          cnt_reg <= cnt_reg + CW'(1);
          // HI/LO stay frozen until the edge that completes the last iteration.
          if (cnt_reg == LAST_ITER) begin
            hi_reg    <= product_next[2*WIDTH-1:WIDTH];
            lo_reg    <= product_next[WIDTH-1:0];
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= ST_DONE;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.HI   = hi_reg;
  assign bus.LO   = lo_reg;
  assign bus.BUSY = busy_reg;
  assign bus.DONE = done_reg;

endmodule

// File: tb/tb_seq_multiplier.sv
// Randomized scoreboard bench for seq_multiplier (WIDTH=32); the reference is plain
// integer multiplication, signed when SEQ_MULT_SIGNED_EN is defined.
module tb_seq_multiplier;
  localparam int W = 32;

  logic CLK;
  logic RST;
  seq_multiplier_if #(.WIDTH(W)) mif ();

  seq_multiplier #(.WIDTH(W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (mif)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  logic [2*W-1:0] sb_q[$];
  logic [2*W-1:0] pub = '0;

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SEQ_MULT_SIGNED_EN
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    return 64'(sa * sb);
`else
    logic [2*W-1:0] ua = {{W{1'b0}}, a};
    logic [2*W-1:0] ub = {{W{1'b0}}, b};
    return ua * ub;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every DONE against the scoreboard and HI/LO stability while busy.
  always @(negedge CLK) begin
    if (mif.DONE === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=%h required=none t=%0t", {mif.HI, mif.LO}, $time);
      end else begin
        logic [2*W-1:0] exp;
        exp = sb_q.pop_front();
        check("product", {mif.HI, mif.LO}, exp);
        $display("txn done hi=%h lo=%h expected=%h", mif.HI, mif.LO, exp);
        pub = exp;
      end
    end else if (mif.BUSY === 1'b1) begin
      check("hold_hilo", {mif.HI, mif.LO}, pub);
    end
  end

  // Called just after a posedge or at a negedge while the DUT is in IDLE or DONE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit keep_start,
                        input int poke, input logic [W-1:0] na, input logic [W-1:0] nb);
    mif.START = 1'b1;
    mif.A = a;
    mif.B = b;
    @(posedge CLK);
    sb_q.push_back(model(a, b));
    #1;
    mif.START = keep_start;
    mif.A = $urandom;
    mif.B = $urandom;
    for (int k = 0; k < W; k++) begin
      @(negedge CLK);
      check("busy_phase", {62'b0, mif.BUSY, mif.DONE}, 64'd2);
      if (k == poke) begin
        mif.START = 1'b1;
        mif.A = 9;
        mif.B = 9;
      end else if (k == poke + 1) begin
        mif.START = keep_start;
      end
    end
    @(negedge CLK);
    check("done_pulse", {62'b0, mif.BUSY, mif.DONE}, 64'd1);
    mif.START = keep_start;
    mif.A = na;
    mif.B = nb;
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      check("idle_flags", {62'b0, mif.BUSY, mif.DONE}, 64'd0);
    end
  endtask

  task automatic reset_mid(input logic [W-1:0] a, input logic [W-1:0] b, input int iter);
    mif.START = 1'b1;
    mif.A = a;
    mif.B = b;
    @(posedge CLK);
    #1;
    mif.START = 1'b0;
    repeat (iter) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("midrst_hilo", {mif.HI, mif.LO}, 64'd0);
    check("midrst_flags", {62'b0, mif.BUSY, mif.DONE}, 64'd0);
    RST = 1'b0;
    pub = '0;
    $display("txn reset_mid a=%h b=%h iter=%0d", a, b, iter);
    idle_gap(W + 4);
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return W'(1);
      2: return '1;
      3: return {1'b1, {(W-1){1'b0}}};
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a, b, na, nb;
    bit chain;
    RST = 1'b1;
    mif.START = 1'b0;
    mif.A = '0;
    mif.B = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_hilo", {mif.HI, mif.LO}, 64'd0);
    check("rst_flags", {62'b0, mif.BUSY, mif.DONE}, 64'd0);
    RST = 1'b0;
    idle_gap(2);

    run_op(32'd3, 32'd5, 1'b0, -1, '0, '0);
    idle_gap(2);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1, '0, '0);
    run_op(32'hFFFF_FFF9, 32'd6, 1'b0, -1, '0, '0);
    idle_gap(1);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, -1, '0, '0);
    idle_gap(1);
    run_op(32'd2, 32'd2, 1'b0, 5, '0, '0);
    idle_gap(3);

    run_op(32'd10, 32'd10, 1'b1, -1, 32'd7, 32'd7);
    run_op(32'd7, 32'd7, 1'b0, -1, '0, '0);
    idle_gap(2);

    run_op(32'd3, 32'd5, 1'b0, -1, '0, '0);
    idle_gap(1);
    reset_mid(32'd4, 32'd4, 10);
    run_op(32'd1, 32'd1, 1'b0, -1, '0, '0);
    idle_gap(1);

    a = pick_operand();
    b = pick_operand();
    for (int n = 0; n < 30; n++) begin
      chain = 1'($urandom_range(0, 1));
      na = pick_operand();
      nb = pick_operand();
      run_op(a, b, chain, $urandom_range(0, 45), na, nb);
      if (chain) begin
        a = na;
        b = nb;
      end else begin
        idle_gap($urandom_range(0, 2));
        a = pick_operand();
        b = pick_operand();
      end
    end

    mif.START = 1'b0;
    idle_gap(3);
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Multi-cycle shift-and-add multiplier for the datapath's MUL instruction. It produces a 2×WIDTH-bit product from two WIDTH-bit operands in WIDTH iterations. Each iteration uses one WIDTH-bit add built from the existing half/full adder chain, plus a single right shift. It sits between the register file operand path and the HI/LO result registers, under a START/DONE handshake with the control unit.

## Interface
- WIDTH, 32, operand width in bits. The product is 2×WIDTH bits. Legal range is 4–64.
- CLK  input  1  clock. All state changes on the rising edge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  request to begin a multiply. Sampled only in IDLE or DONE state.
- A  input  WIDTH  multiplicand. Sampled on the accepting edge only.
- B  input  WIDTH  multiplier. Sampled on the accepting edge only.
- HI  output  WIDTH  upper half of the last completed product.
- LO  output  WIDTH  lower half of the last completed product.
- BUSY  output  1  high while an operation is in progress.
- DONE  output  1  one-cycle pulse when HI/LO have been updated.

## Operation
- States:
  - IDLE: reset state.
  - RUN: iterating.
  - DONE: one cycle, result published.
- IDLE:
  - START=1 → latch the multiplicand register M=A and the shift register Q=B.
  - Clear the accumulator ACC (WIDTH+1 bits, includes the carry bit).
  - Clear the iteration counter CNT (width clog2(WIDTH)+1).
  - Go to RUN.
  - START=0 → stay in IDLE.
- RUN, each edge:
  - If Q[0]=1, then {C,S} = ACC[WIDTH-1:0] + M; otherwise {C,S} = {0, ACC[WIDTH-1:0]}.
  - Then {ACC,Q} ← {C, S, Q} >> 1, i.e. {ACC,Q} ← {C, S, Q[WIDTH-1:1]}.
  - CNT ← CNT+1.
  - When CNT = WIDTH-1 on an edge, that edge performs the last iteration and also:
    - loads HI=ACC and LO=Q from the post-iteration values;
    - goes to DONE.
- DONE:
  - DONE=1 and BUSY=0 for exactly one cycle.
  - START=1 in DONE is accepted exactly as in IDLE, giving back-to-back operation. Otherwise go to IDLE.
- START while BUSY is ignored. No queueing, no error flag.
- A and B may change freely after the accepting edge.
- HI and LO hold the previous result throughout RUN. They change only on the edge that enters DONE.
- Reset values: HI=0, LO=0, BUSY=0, DONE=0, state=IDLE, and all internal registers 0.
- RST=1 mid-operation aborts the operation with no DONE pulse. RST has priority over START.

## Timing
- Accepting edge t0 → BUSY=1 from t0 to t0+WIDTH.
- Iterations occur on edges t0+1 … t0+WIDTH.
- HI/LO are valid and DONE=1 after edge t0+WIDTH, for one cycle.
- Latency from START to DONE is WIDTH+1 edges. Throughput is one product per WIDTH+1 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- SEQ_MULT_SIGNED_EN defined: A and B are two's complement.
  - The accepting edge latches M=|A| and Q=|B|, plus a sign flag equal to A[WIDTH-1]^B[WIDTH-1].
  - |−2^(WIDTH-1)| = 2^(WIDTH-1) is taken as an unsigned value.
  - On the final iteration edge, {HI,LO} is loaded with the two's-complement negation of {ACC,Q} if the sign flag is set.
  - Latency is unchanged.
- Not defined: unsigned multiply, with no sign logic present.

## Test plan
- Basic unsigned multiply:
  - Stimulus: WIDTH=32, A=3, B=5, START pulsed one cycle.
  - Response: BUSY high for 32 cycles; after edge t0+32, DONE=1, HI=0x00000000, LO=0x0000000F.
- Full-range operands:
  - Stimulus: A=B=0xFFFFFFFF.
  - Response unsigned: HI=0xFFFFFFFE, LO=0x00000001.
  - Response with SEQ_MULT_SIGNED_EN: HI=0x00000000, LO=0x00000001.
- Signed operands (with SEQ_MULT_SIGNED_EN):
  - A=0xFFFFFFF9 (−7), B=6 → HI=0xFFFFFFFF, LO=0xFFFFFFD6.
  - A=B=0x80000000 → HI=0x40000000, LO=0x00000000.
- START while busy:
  - Stimulus: A=2, B=2 accepted; at iteration 5, START=1 with A=9, B=9.
  - Response: the second request is ignored; DONE once with LO=4; then state returns to IDLE.
- Back-to-back operation:
  - Stimulus: START held high continuously with A=10, B=10, then A=7, B=7 presented during the DONE cycle.
  - Response: the first DONE gives LO=100; the second operation is accepted at the DONE edge; the second DONE comes 33 cycles later with LO=49.
- Reset mid-operation:
  - Stimulus: after a previous result LO=15, start A=4, B=4; assert RST=1 for one cycle at iteration 10.
  - Response: HI=LO=0, BUSY=0, DONE never pulses; the next START with A=1, B=1 gives LO=1 with normal latency.
